ysyx_23060061_axi_arbiter: RTL and testbench

//  2-master -> 1-slave AXI4 arbiter directly downstream of the LSU and IFU AXI4 master ports.

---
 rtl/ysyx_23060061_axi_arbiter_pkg.sv | 24 ++
 rtl/ysyx_23060061_arb_pick.sv | 27 ++
 rtl/ysyx_23060061_axi_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ysyx_23060061_axi_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060061_axi_arbiter_pkg.sv
// Shared definitions for the 2-master AXI4 arbiter: grant states, master indices, AXI codes.
package ysyx_23060061_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4
    } state_e;

    localparam int M_IFU = 0;
    localparam int M_LSU = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // A write only counts as a request once both address and data are offered.
    function automatic logic is_req(input logic arvalid, input logic awvalid, input logic wvalid);
        return arvalid | (awvalid & wvalid);
    endfunction

endpackage

// File: rtl/ysyx_23060061_arb_pick.sv
// Two-way one-hot picker. Round-robin tie-break under YSYX_23060061_ARB_RR_EN,
// otherwise the LSU (index 1) always wins a tie.
module ysyx_23060061_arb_pick
    import ysyx_23060061_axi_arbiter_pkg::*;
(
    input  logic [1:0] req,
`ifdef YSYX_23060061_ARB_RR_EN
    input  logic       rr_last,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = 2'b00;
`ifdef YSYX_23060061_ARB_RR_EN
            // The master that did not win the previous grant goes first.
            if (rr_last) gnt[M_IFU] = 1'b1;
            else         gnt[M_LSU] = 1'b1;
`else
            gnt[M_LSU] = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/ysyx_23060061_axi_arbiter.sv
// 2-master (IFU=m0, LSU=m1) to 1-slave AXI4 arbiter, one whole transaction per grant.
// Tie-break policy selected by YSYX_23060061_ARB_RR_EN (round-robin) else fixed LSU priority.
module ysyx_23060061_axi_arbiter
    import ysyx_23060061_axi_arbiter_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4
) (
    input  logic            clk,
    input  logic            rst,
    // m0 (IFU)
    input  logic            m0_arvalid,
    input  logic [AW-1:0]   m0_araddr,
    input  logic [IDW-1:0]  m0_arid,
    input  logic [7:0]      m0_arlen,
    input  logic [2:0]      m0_arsize,
    input  logic [1:0]      m0_arburst,
    output logic            m0_arready,
    output logic [DW-1:0]   m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rvalid,
    output logic            m0_rlast,
    output logic [IDW-1:0]  m0_rid,
    input  logic            m0_rready,
    input  logic            m0_awvalid,
    input  logic [AW-1:0]   m0_awaddr,
    input  logic [IDW-1:0]  m0_awid,
    input  logic [7:0]      m0_awlen,
    input  logic [2:0]      m0_awsize,
    input  logic [1:0]      m0_awburst,
    output logic            m0_awready,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_wvalid,
    input  logic            m0_wlast,
    output logic            m0_wready,
    output logic [1:0]      m0_bresp,
    output logic            m0_bvalid,
    output logic [IDW-1:0]  m0_bid,
    input  logic            m0_bready,
    // m1 (LSU)
    input  logic            m1_arvalid,
    input  logic [AW-1:0]   m1_araddr,
    input  logic [IDW-1:0]  m1_arid,
    input  logic [7:0]      m1_arlen,
    input  logic [2:0]      m1_arsize,
    input  logic [1:0]      m1_arburst,
    output logic            m1_arready,
    output logic [DW-1:0]   m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rvalid,
    output logic            m1_rlast,
    output logic [IDW-1:0]  m1_rid,
    input  logic            m1_rready,
    input  logic            m1_awvalid,
    input  logic [AW-1:0]   m1_awaddr,
    input  logic [IDW-1:0]  m1_awid,
    input  logic [7:0]      m1_awlen,
    input  logic [2:0]      m1_awsize,
    input  logic [1:0]      m1_awburst,
    output logic            m1_awready,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_wvalid,
    input  logic            m1_wlast,
    output logic            m1_wready,
    output logic [1:0]      m1_bresp,
    output logic            m1_bvalid,
    output logic [IDW-1:0]  m1_bid,
    input  logic            m1_bready,
    // slave
    output logic            s_arvalid,
    output logic [AW-1:0]   s_araddr,
    output logic [IDW-1:0]  s_arid,
    output logic [7:0]      s_arlen,
    output logic [2:0]      s_arsize,
    output logic [1:0]      s_arburst,
    input  logic            s_arready,
    input  logic [DW-1:0]   s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rvalid,
    input  logic            s_rlast,
    input  logic [IDW-1:0]  s_rid,
    output logic            s_rready,
    output logic            s_awvalid,
    output logic [AW-1:0]   s_awaddr,
    output logic [IDW-1:0]  s_awid,
    output logic [7:0]      s_awlen,
    output logic [2:0]      s_awsize,
    output logic [1:0]      s_awburst,
    input  logic            s_awready,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    output logic            s_wvalid,
    output logic            s_wlast,
    input  logic            s_wready,
    input  logic [1:0]      s_bresp,
    input  logic            s_bvalid,
    input  logic [IDW-1:0]  s_bid,
    output logic            s_bready
);

    state_e     state_q, state_d;
    logic [1:0] req, gnt;
    logic       rd_act, wr_act, sel_m1;

    assign req = {is_req(m1_arvalid, m1_awvalid, m1_wvalid),
                  is_req(m0_arvalid, m0_awvalid, m0_wvalid)};

`ifdef YSYX_23060061_ARB_RR_EN
    logic rr_last_q, rr_last_d;

    assign rr_last_d = (state_q == ST_IDLE && gnt != 2'b00) ? gnt[M_LSU] : rr_last_q;

    always_ff @(posedge clk) begin
        if (!rst) rr_last_q <= 1'b0;
        else      rr_last_q <= rr_last_d;
    end

    ysyx_23060061_arb_pick u_pick (.req(req), .rr_last(rr_last_q), .gnt(gnt));
`else
    ysyx_23060061_arb_pick u_pick (.req(req), .gnt(gnt));
`endif

    // NOTE: reset is synchronous (rst sampled only on clk), and state flops use <= so every
    // flop sees pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt[M_LSU])      state_d = (m1_awvalid & m1_wvalid) ? ST_WR1 : ST_RD1;
                else if (gnt[M_IFU]) state_d = (m0_awvalid & m0_wvalid) ? ST_WR0 : ST_RD0;
            end
            ST_RD0, ST_RD1: if (s_rvalid & s_rready & s_rlast) state_d = ST_IDLE;
            ST_WR0, ST_WR1: if (s_bvalid & s_bready)           state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    assign rd_act = (state_q == ST_RD0) || (state_q == ST_RD1);
    assign wr_act = (state_q == ST_WR0) || (state_q == ST_WR1);
    assign sel_m1 = (state_q == ST_RD1) || (state_q == ST_WR1);

    // Payloads are muxed freely; only valids/readies are gated by the grant.
    assign s_araddr  = sel_m1 ? m1_araddr  : m0_araddr;
    assign s_arid    = sel_m1 ? m1_arid    : m0_arid;
    assign s_arlen   = sel_m1 ? m1_arlen   : m0_arlen;
    assign s_arsize  = sel_m1 ? m1_arsize  : m0_arsize;
    assign s_arburst = sel_m1 ? m1_arburst : m0_arburst;
    assign s_awaddr  = sel_m1 ? m1_awaddr  : m0_awaddr;
    assign s_awid    = sel_m1 ? m1_awid    : m0_awid;
    assign s_awlen   = sel_m1 ? m1_awlen   : m0_awlen;
    assign s_awsize  = sel_m1 ? m1_awsize  : m0_awsize;
    assign s_awburst = sel_m1 ? m1_awburst : m0_awburst;
    assign s_wdata   = sel_m1 ? m1_wdata   : m0_wdata;
    assign s_wstrb   = sel_m1 ? m1_wstrb   : m0_wstrb;
    assign s_wlast   = sel_m1 ? m1_wlast   : m0_wlast;

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m0_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign m0_bresp = s_bresp;
    assign m0_bid   = s_bid;
    assign m1_bresp = s_bresp;
    assign m1_bid   = s_bid;

    always_comb begin
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        if (rd_act) begin
            s_arvalid  = sel_m1 ? m1_arvalid : m0_arvalid;
            s_rready   = sel_m1 ? m1_rready  : m0_rready;
            m0_arready = !sel_m1 & s_arready;
            m0_rvalid  = !sel_m1 & s_rvalid;
            m1_arready =  sel_m1 & s_arready;
            m1_rvalid  =  sel_m1 & s_rvalid;
        end
        if (wr_act) begin
            s_awvalid  = sel_m1 ? m1_awvalid : m0_awvalid;
            s_wvalid   = sel_m1 ? m1_wvalid  : m0_wvalid;
            s_bready   = sel_m1 ? m1_bready  : m0_bready;
            m0_awready = !sel_m1 & s_awready;
            m0_wready  = !sel_m1 & s_wready;
            m0_bvalid  = !sel_m1 & s_bvalid;
            m1_awready =  sel_m1 & s_awready;
            m1_wready  =  sel_m1 & s_wready;
            m1_bvalid  =  sel_m1 & s_bvalid;
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_axi_arbiter.sv
// Self-checking bench for ysyx_23060061_axi_arbiter: directed scenarios then random traffic,
// with the bench playing both masters and the slave; grant order comes from a priority model.
module tb_ysyx_23060061_axi_arbiter;
    import ysyx_23060061_axi_arbiter_pkg::*;

`ifdef YSYX_23060061_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_arvalid[2], m_arready[2], m_rvalid[2], m_rlast[2], m_rready[2];
    logic        m_awvalid[2], m_awready[2], m_wvalid[2], m_wlast[2], m_wready[2];
    logic        m_bvalid[2], m_bready[2];
    logic [31:0] m_araddr[2], m_rdata[2], m_awaddr[2], m_wdata[2];
    logic [3:0]  m_arid[2], m_rid[2], m_awid[2], m_bid[2], m_wstrb[2];
    logic [7:0]  m_arlen[2], m_awlen[2];
    logic [2:0]  m_arsize[2], m_awsize[2];
    logic [1:0]  m_arburst[2], m_awburst[2], m_rresp[2], m_bresp[2];

    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  s_arid, s_rid, s_awid, s_bid, s_wstrb;
    logic [7:0]  s_arlen, s_awlen;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;

    ysyx_23060061_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m_arvalid[0]), .m0_araddr(m_araddr[0]), .m0_arid(m_arid[0]), .m0_arlen(m_arlen[0]),
        .m0_arsize(m_arsize[0]), .m0_arburst(m_arburst[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rlast(m_rlast[0]),
        .m0_rid(m_rid[0]), .m0_rready(m_rready[0]),
        .m0_awvalid(m_awvalid[0]), .m0_awaddr(m_awaddr[0]), .m0_awid(m_awid[0]), .m0_awlen(m_awlen[0]),
        .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wlast(m_wlast[0]),
        .m0_wready(m_wready[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bid(m_bid[0]),
        .m0_bready(m_bready[0]),
        .m1_arvalid(m_arvalid[1]), .m1_araddr(m_araddr[1]), .m1_arid(m_arid[1]), .m1_arlen(m_arlen[1]),
        .m1_arsize(m_arsize[1]), .m1_arburst(m_arburst[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rlast(m_rlast[1]),
        .m1_rid(m_rid[1]), .m1_rready(m_rready[1]),
        .m1_awvalid(m_awvalid[1]), .m1_awaddr(m_awaddr[1]), .m1_awid(m_awid[1]), .m1_awlen(m_awlen[1]),
        .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wlast(m_wlast[1]),
        .m1_wready(m_wready[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bid(m_bid[1]),
        .m1_bready(m_bready[1]),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bready(s_bready)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: what each master currently requests (0 none, 1 read, 2 write).
    int          kind[2];
    logic [31:0] req_addr[2], req_data[2];
    logic [3:0]  req_id[2], req_strb[2];
    int          req_len[2];
    int          rr_m;

    int          cfg_ar_dly, cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_late;
    bit          cfg_fix_data, cfg_fix_resp;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_resp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                    m_arready[0], m_awready[0], m_wready[0], m_rvalid[0], m_bvalid[0],
                    m_arready[1], m_awready[1], m_wready[1], m_rvalid[1], m_bvalid[1]}, 64'd0);
    endtask

    task automatic check_loser(input int l, input string tag);
        check(tag, {m_arready[l], m_awready[l], m_wready[l], m_rvalid[l], m_bvalid[l]}, 64'd0);
    endtask

    // Tie rule: both requesting -> LSU (fixed) or the master that did not win last (round-robin).
    function automatic int model_pick(input bit p0, input bit p1);
        if (p0 && p1) return (RR_EN && rr_m == 1) ? 0 : 1;
        return p1 ? 1 : 0;
    endfunction

    task automatic cfg_rand();
        cfg_ar_dly   = $urandom_range(0, 2);
        cfg_aw_dly   = $urandom_range(0, 2);
        cfg_w_dly    = $urandom_range(0, 2);
        cfg_b_dly    = $urandom_range(0, 2);
        cfg_late     = -1;
        cfg_fix_data = 1'b0;
        cfg_fix_resp = 1'b0;
    endtask

    task automatic set_read(input int w, input logic [31:0] addr, input int len);
        kind[w] = 1; req_addr[w] = addr; req_len[w] = len; req_id[w] = 4'($urandom);
        m_arvalid[w] = 1'b1; m_araddr[w] = addr; m_arid[w] = req_id[w];
        m_arlen[w] = 8'(len); m_arsize[w] = 3'd2; m_arburst[w] = BURST_INCR;
    endtask

    task automatic set_write(input int w, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        kind[w] = 2; req_addr[w] = addr; req_data[w] = data; req_strb[w] = strb; req_len[w] = 0;
        req_id[w] = 4'($urandom);
        m_awvalid[w] = 1'b1; m_awaddr[w] = addr; m_awid[w] = req_id[w]; m_awlen[w] = 8'd0;
        m_awsize[w] = 3'd2; m_awburst[w] = BURST_INCR;
        m_wvalid[w] = 1'b1; m_wdata[w] = data; m_wstrb[w] = strb; m_wlast[w] = 1'b1;
    endtask

    // Entered just after a posedge with the DUT idle; returns just after the final handshake edge.
    task automatic do_txn(input int w);
        int l;
        int d, d_aw, d_w;
        bit hs, hs_aw, hs_w, done, is_wr;
        logic [31:0] dat;
        logic [1:0]  rsp;
        l = 1 - w;
        is_wr = (kind[w] == 2);
        if (is_wr) begin
            s_awready = (cfg_aw_dly == 0);
            s_wready  = (cfg_w_dly == 0);
        end else begin
            s_arready = (cfg_ar_dly == 0);
        end
        @(negedge clk);
        check_idle("bubble");
        @(negedge clk);
        check("grant_ar", s_arvalid, !is_wr);
        check("grant_aw", s_awvalid, is_wr);
        check_loser(l, "loser_grant");
        if (!is_wr) begin
            check("araddr", s_araddr, req_addr[w]);
            check("arid", s_arid, req_id[w]);
            check("arlen", s_arlen, req_len[w]);
            d = cfg_ar_dly;
            hs = 1'b0;
            for (int k = 0; k < 20 && !hs; k++) begin
                check("arready_route", m_arready[w], s_arready);
                check_loser(l, "loser_ar");
                hs = s_arready && m_arvalid[w];
                @(posedge clk); #1;
                if (!hs) begin
                    d--;
                    s_arready = (d <= 0);
                    @(negedge clk);
                end
            end
            check("ar_handshake", hs, 1);
            m_arvalid[w] = 1'b0;
            s_arready = 1'b0;
            if (cfg_late >= 0) begin
                set_read(cfg_late, $urandom, 0);
                cfg_late = -1;
            end
            for (int b = 0; b <= req_len[w]; b++) begin
                s_rvalid = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    @(negedge clk);
                    check("rgap_rvalid", m_rvalid[w], 0);
                    check_loser(l, "loser_rgap");
                    @(posedge clk); #1;
                end
                dat = cfg_fix_data ? cfg_rdata : $urandom;
                rsp = cfg_fix_resp ? cfg_resp : ($urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY);
                s_rvalid = 1'b1; s_rdata = dat; s_rresp = rsp;
                s_rlast = (b == req_len[w]); s_rid = req_id[w];
                m_rready[w] = 1'($urandom_range(0, 1));
                hs = 1'b0;
                for (int k = 0; k < 20 && !hs; k++) begin
                    @(negedge clk);
                    check("rvalid", m_rvalid[w], 1);
                    check("rdata", m_rdata[w], dat);
                    check("rresp", m_rresp[w], rsp);
                    check("rlast", m_rlast[w], (b == req_len[w]));
                    check("rid", m_rid[w], req_id[w]);
                    check("rready_route", s_rready, m_rready[w]);
                    check_loser(l, "loser_r");
                    hs = m_rready[w];
                    @(posedge clk); #1;
                    if (!hs) m_rready[w] = (k >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                end
                check("r_handshake", hs, 1);
            end
            s_rvalid = 1'b0; s_rlast = 1'b0; m_rready[w] = 1'b0;
        end else begin
            check("awaddr", s_awaddr, req_addr[w]);
            check("awid", s_awid, req_id[w]);
            check("wdata", s_wdata, req_data[w]);
            check("wstrb", s_wstrb, req_strb[w]);
            check("wlast", s_wlast, 1);
            d_aw = cfg_aw_dly;
            d_w  = cfg_w_dly;
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                check("awready_route", m_awready[w], s_awready);
                check("wready_route", m_wready[w], s_wready);
                check("awvalid_route", s_awvalid, m_awvalid[w]);
                check("wvalid_route", s_wvalid, m_wvalid[w]);
                check_loser(l, "loser_aw");
                hs_aw = s_awready && m_awvalid[w];
                hs_w  = s_wready && m_wvalid[w];
                @(posedge clk); #1;
                if (hs_aw) begin
                    m_awvalid[w] = 1'b0; s_awready = 1'b0;
                end else if (m_awvalid[w]) begin
                    d_aw--; s_awready = (d_aw <= 0);
                end
                if (hs_w) begin
                    m_wvalid[w] = 1'b0; s_wready = 1'b0;
                end else if (m_wvalid[w]) begin
                    d_w--; s_wready = (d_w <= 0);
                end
                done = !m_awvalid[w] && !m_wvalid[w];
                if (!done) @(negedge clk);
            end
            check("aw_w_done", done, 1);
            d = cfg_b_dly;
            rsp = cfg_fix_resp ? cfg_resp : ($urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY);
            s_bvalid = 1'b1; s_bresp = rsp; s_bid = req_id[w];
            m_bready[w] = (d == 0);
            hs = 1'b0;
            for (int k = 0; k < 20 && !hs; k++) begin
                @(negedge clk);
                check("bvalid", m_bvalid[w], 1);
                check("bresp", m_bresp[w], rsp);
                check("bid", m_bid[w], req_id[w]);
                check("bready_route", s_bready, m_bready[w]);
                check_loser(l, "loser_b");
                hs = m_bready[w];
                @(posedge clk); #1;
                if (!hs) begin
                    d--; m_bready[w] = (d <= 0);
                end
            end
            check("b_handshake", hs, 1);
            s_bvalid = 1'b0; m_bready[w] = 1'b0;
        end
        kind[w] = 0;
    endtask

    task automatic serve();
        int w;
        w = model_pick(kind[0] != 0, kind[1] != 0);
        rr_m = w;
        do_txn(w);
        cfg_rand();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            kind[i] = 0;
            m_arvalid[i] = 0; m_rready[i] = 0; m_awvalid[i] = 0; m_wvalid[i] = 0; m_bready[i] = 0;
            m_araddr[i] = 0; m_arid[i] = 0; m_arlen[i] = 0; m_arsize[i] = 0; m_arburst[i] = 0;
            m_awaddr[i] = 0; m_awid[i] = 0; m_awlen[i] = 0; m_awsize[i] = 0; m_awburst[i] = 0;
            m_wdata[i] = 0; m_wstrb[i] = 0; m_wlast[i] = 0;
        end
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
        rr_m = 0;
        cfg_rand();

        // Reset holds everything idle even with a request pending.
        set_read(0, 32'h8000_0040, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_idle");
        @(posedge clk); #1;
        rst = 1'b1;
        serve();

        // Single LSU read returning 0xDEADBEEF.
        set_read(1, 32'h8000_0010, 0);
        cfg_fix_data = 1'b1; cfg_rdata = 32'hDEAD_BEEF;
        serve();

        // Same-cycle reads from both masters.
        set_read(0, 32'h8000_0000, 0);
        set_read(1, 32'h8000_0100, 0);
        serve();
        serve();

        // LSU write with a 3-cycle bready delay while the IFU read waits.
        set_write(1, 32'h8000_0004, 32'h0000_AB00, 4'b0010);
        set_read(0, 32'h8000_0200, 0);
        cfg_b_dly = 3; cfg_fix_resp = 1'b1; cfg_resp = RESP_OKAY;
        serve();
        serve();

        // IFU 4-beat burst with an LSU read raised mid-transaction.
        set_read(0, 32'h8000_1000, 3);
        cfg_late = 1;
        serve();
        serve();

        // Reset while in RD1 with rvalid pending.
        set_read(1, 32'h8000_0020, 0);
        s_arready = 1'b1;
        @(negedge clk);
        check_idle("rst_bubble");
        @(negedge clk);
        check("rst_grant", s_arvalid, 1);
        @(posedge clk); #1;
        m_arvalid[1] = 1'b0; s_arready = 1'b0; kind[1] = 0;
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rlast = 1'b1; s_rresp = RESP_OKAY;
        m_rready[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_pre_rvalid", m_rvalid[1], 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_idle("rst_mid_txn");
        @(posedge clk); #1;
        rst = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0;
        rr_m = 0;

        // SLVERR read response forwarded unchanged.
        set_read(1, 32'h8000_0030, 0);
        cfg_fix_resp = 1'b1; cfg_resp = RESP_SLVERR;
        serve();

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < 2; w++) begin
                if (kind[w] == 0 && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 1) == 1) set_read(w, $urandom, $urandom_range(0, 3));
                    else                           set_write(w, $urandom, $urandom, 4'($urandom));
                end
            end
            if (kind[0] == 0 && kind[1] == 0) set_read($urandom_range(0, 1), $urandom, 1);
            serve();
        end
        while (kind[0] != 0 || kind[1] != 0) serve();

        @(negedge clk);
        check_idle("final_idle");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
